ram_dp_clr: RTL and testbench

- Parametrised, synthesisable simple-dual-port RAM: one write port and one read port, on a single clock.
- Generalises the fixed 256x16 iCE40 block RAM primitive to any width and depth.
- Adds a per-bit write mask, a read-valid strobe, and a hardware clear engine that fills the array with a constant after reset or on request.
- Used for the CPU register file, scratch RAM and FIFOs; the synthesiser infers EBR from it.

---
 rtl/ram_dp_clr.sv | 112 +++++++++++
 tb/tb_ram_dp_clr.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_clr.sv
// ram_dp_clr: simple-dual-port RAM with per-bit write mask and a clear engine.
// Define RAM_DP_CLR_BYPASS_EN for write-first same-address forwarding.
module ram_dp_clr #(
    parameter int                DATA_W    = 16,
    parameter int                DEPTH     = 256,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr_req,
    output logic                       busy,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_W-1:0]          wmask,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       re,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_W-1:0]          rdata,
    output logic                       rvalid
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rd_word;
    logic                idle;
    logic                wr_ok;
    logic                rd_ok;
    logic                wr_hit;

    assign idle   = (state == S_IDLE);
    assign wr_ok  = idle && we && ({1'b0, waddr} < DEPTH_X);
    assign rd_ok  = ({1'b0, raddr} < DEPTH_X);
    assign wr_hit = wr_ok && (waddr == raddr);

    // Clear sequencer: walk every word once, then hand the array to the user.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            unique case (state)
                S_CLEAR: begin
                    if (cnt == LAST) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (clr_req) begin
                        state <= S_CLEAR;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
            endcase
        end
    end

    // Array write port: clear engine has priority, user writes are masked.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            mem[cnt] <= CLEAR_VAL;
        end else if (wr_ok) begin
            mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
        end
    end

    // Read word select: out-of-range reads see the clear value.
    always_comb begin
        rd_word = CLEAR_VAL;
        if (rd_ok) begin
            rd_word = mem[raddr];
        end
`ifdef RAM_DP_CLR_BYPASS_EN
        if (rd_ok && wr_hit) begin
            rd_word = (mem[raddr] & ~wmask) | (wdata & wmask);
        end
`else
        if (wr_hit) begin
            rd_word = rd_word;
        end
`endif
    end

    // Registered read port, gated off while the clear engine runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else if (idle && re) begin
            rdata  <= rd_word;
            rvalid <= 1'b1;
        end else begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_dp_clr.sv
// tb_ram_dp_clr: directed bench for ram_dp_clr (16x12, clear value A5A5).
// Expected values are hand-computed from the masked-write rule.
module tb_ram_dp_clr;

    logic        clk;
    logic        rst_n;
    logic        clr_req;
    logic        busy;
    logic        we;
    logic [3:0]  waddr;
    logic [15:0] wmask;
    logic [15:0] wdata;
    logic        re;
    logic [3:0]  raddr;
    logic [15:0] rdata;
    logic        rvalid;

    int total;
    int fails;
    int k;

    ram_dp_clr #(
        .DATA_W   (16),
        .DEPTH    (12),
        .CLEAR_VAL(16'hA5A5)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_req(clr_req),
        .busy   (busy),
        .we     (we),
        .waddr  (waddr),
        .wmask  (wmask),
        .wdata  (wdata),
        .re     (re),
        .raddr  (raddr),
        .rdata  (rdata),
        .rvalid (rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d,
                      input logic [15:0] m);
        we = 1'b1; waddr = a; wdata = d; wmask = m;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        re = 1'b1; raddr = a;
        tick();
        re = 1'b0;
    endtask

    task automatic wait_idle;
        while (busy && k < 60) begin
            tick();
            k++;
        end
    endtask

    initial begin
        total = 0; fails = 0; k = 0;
        rst_n = 1'b0; clr_req = 1'b0; we = 1'b0; re = 1'b0;
        waddr = '0; raddr = '0; wmask = '0; wdata = '0;
        tick(); tick();
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h1);

        rst_n = 1'b1;
        k = 0;
        wait_idle();
        chk("init_clear_len", 32'(k), 32'd12);

        for (int i = 0; i < 12; i++) begin
            rd(4'(i));
            chk($sformatf("init_rd%0d", i), 32'(rdata), 32'hA5A5);
            chk($sformatf("init_rv%0d", i), 32'(rvalid), 32'h1);
        end
        tick();
        chk("rv_drop", 32'(rvalid), 32'h0);

        wr(4'd3, 16'h1234, 16'hFFFF);
        wr(4'd3, 16'hFF00, 16'h0F0F);
        rd(4'd3);
        chk("mask_merge", 32'(rdata), 32'h1F30);
        tick();
        chk("hold_rv", 32'(rvalid), 32'h0);
        chk("hold_rdata", 32'(rdata), 32'h1F30);

        wr(4'd5, 16'h0001, 16'hFFFF);
        we = 1'b1; waddr = 4'd5; wdata = 16'hBEEF; wmask = 16'hFFFF;
        re = 1'b1; raddr = 4'd5;
        tick();
        we = 1'b0; re = 1'b0;
`ifdef RAM_DP_CLR_BYPASS_EN
        chk("collide", 32'(rdata), 32'hBEEF);
`else
        chk("collide", 32'(rdata), 32'h0001);
`endif
        wr(4'd5, 16'h0000, 16'h0000);
        rd(4'd5);
        chk("nomask_noop", 32'(rdata), 32'hBEEF);

        we = 1'b1; waddr = 4'd6; wdata = 16'h1111; wmask = 16'hFFFF;
        re = 1'b1; raddr = 4'd3;
        tick();
        we = 1'b0; re = 1'b0;
        chk("indep_rd", 32'(rdata), 32'h1F30);
        rd(4'd6);
        chk("indep_wr", 32'(rdata), 32'h1111);

        wr(4'd7, 16'h7777, 16'hFFFF);
        clr_req = 1'b1; re = 1'b1; raddr = 4'd5;
        tick();
        clr_req = 1'b0; re = 1'b0;
        chk("clr_busy", 32'(busy), 32'h1);
        chk("clr_edge_rv", 32'(rvalid), 32'h1);
        chk("clr_edge_rd", 32'(rdata), 32'hBEEF);
        k = 0;
        tick(); tick(); tick();
        k = 3;
        clr_req = 1'b1;
        we = 1'b1; waddr = 4'd7; wdata = 16'h1234; wmask = 16'hFFFF;
        re = 1'b1; raddr = 4'd6;
        tick();
        k++;
        clr_req = 1'b0; we = 1'b0; re = 1'b0;
        chk("busy_rv", 32'(rvalid), 32'h0);
        chk("busy_hold", 32'(rdata), 32'hBEEF);
        wait_idle();
        chk("clr_len", 32'(k), 32'd12);
        rd(4'd7);
        chk("busy_wr_drop", 32'(rdata), 32'hA5A5);
        rd(4'd3);
        chk("clr_w3", 32'(rdata), 32'hA5A5);

        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rdata", 32'(rdata), 32'h0);
        chk("mid_rst_rv", 32'(rvalid), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h1);
        tick(); tick(); tick();
        rst_n = 1'b1;
        k = 0;
        wait_idle();
        chk("rst_clr_len", 32'(k), 32'd12);

        wr(4'd13, 16'hDEAD, 16'hFFFF);
        rd(4'd13);
        chk("oor_rd", 32'(rdata), 32'hA5A5);
        chk("oor_rv", 32'(rvalid), 32'h1);
        wr(4'd1, 16'h0F0F, 16'hFFFF);
        rd(4'd15);
        chk("oor_rd15", 32'(rdata), 32'hA5A5);
        rd(4'd1);
        chk("oor_w1", 32'(rdata), 32'h0F0F);
        for (int i = 2; i < 12; i++) begin
            rd(4'(i));
            chk($sformatf("oor_keep%0d", i), 32'(rdata), 32'hA5A5);
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
